// File: rtl/chi_tx_lcrd_ctrl.sv
// CHI TX L-credit controller: tracks link-layer credits, gates data flits, returns credits on deactivation.
// Latency: zero-cycle flit send (req_ready/flitv combinational); crd_cnt, deact_done, err registered.
// Backpressure: req_ready drops when no credit is held or link is not Run; optional sent_cnt via CHI_LCRD_STATS_EN.
module chi_tx_lcrd_ctrl #(
    parameter int unsigned MAX_CRD = 15
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [2:0] tx_state,
    input  logic       lcrdv,
    input  logic       req_valid,
    output logic       req_ready,
    output logic       flitv,
    output logic       flit_is_ret,
    output logic [3:0] crd_cnt,
    output logic       deact_done,
    output logic       err
`ifdef CHI_LCRD_STATS_EN
    ,
    output logic [15:0] sent_cnt
`endif
);

    localparam logic [2:0] TX_RUN   = 3'd4;
    localparam logic [2:0] TX_DEACT = 3'd5;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_CRD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RETURN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] crd_cnt_q, crd_cnt_d;
    logic       err_q, err_d;
    logic       deact_done_q, deact_done_d;

    logic tx_run, tx_deact, has_crd;
    logic data_send, ret_send, flit_send, crd_inc;

    // Flit issue: data flits pass straight through when a credit is held; return flits drain credits.
    // Everything is masked while reset is asserted so no flit escapes an abandoned return.
    always_comb begin
        tx_run    = (tx_state == TX_RUN);
        tx_deact  = (tx_state == TX_DEACT);
        has_crd   = (crd_cnt_q != 4'd0);
        req_ready = ARESETn && (state_q == ST_RUN) && tx_run && has_crd;
        data_send = req_ready && req_valid;
        ret_send  = ARESETn && (state_q == ST_RETURN) && has_crd;
        flit_send = data_send || ret_send;
        crd_inc   = lcrdv && (tx_run || tx_deact);
    end

    assign flitv       = flit_send;
    assign flit_is_ret = ret_send;

    // Next-state logic for the credit-controller FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_run)        state_d = ST_RUN;
                else if (tx_deact) state_d = ST_RETURN;
            end
            ST_RUN: begin
                if (tx_deact)    state_d = ST_RETURN;
                else if (!tx_run) state_d = ST_IDLE;
            end
            ST_RETURN: begin
                if (!tx_deact)                        state_d = ST_IDLE;
                else if (!has_crd && !lcrdv)          state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!tx_deact)  state_d = ST_IDLE;
                else if (lcrdv) state_d = ST_RETURN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Credit counter and sticky error: grant and send in the same cycle cancel out;
    // grants outside Run/Deact or beyond MAX_CRD are dropped and flagged.
    always_comb begin
        crd_cnt_d = crd_cnt_q;
        err_d     = err_q;
        if (lcrdv && !(tx_run || tx_deact)) begin
            err_d = 1'b1;
        end
        if (crd_inc && !flit_send) begin
            if (crd_cnt_q >= MAX_CNT) begin
                err_d = 1'b1;
            end else begin
                crd_cnt_d = crd_cnt_q + 4'd1;
            end
        end else if (!crd_inc && flit_send) begin
            crd_cnt_d = crd_cnt_q - 4'd1;
        end
        // Falling back to IDLE means the link dropped; held credits are void.
        if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            crd_cnt_d = 4'd0;
        end
        deact_done_d = (state_d == ST_DONE);
    end

    // State, counter and status registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            crd_cnt_q    <= 4'd0;
            err_q        <= 1'b0;
            deact_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            crd_cnt_q    <= crd_cnt_d;
            err_q        <= err_d;
            deact_done_q <= deact_done_d;
        end
    end

    assign crd_cnt    = crd_cnt_q;
    assign err        = err_q;
    assign deact_done = deact_done_q;

`ifdef CHI_LCRD_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;

    // Saturating count of data flits; credit-return flits are not counted.
    always_comb begin
        sent_cnt_d = sent_cnt_q;
        if (data_send && (sent_cnt_q != 16'hFFFF)) begin
            sent_cnt_d = sent_cnt_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            sent_cnt_q <= 16'd0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign sent_cnt = sent_cnt_q;
`endif

endmodule
